// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer / watchdog.
package rst_seq_pkg;

   localparam int RESTART_CNT_W = 8;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      EXPIRED = 2'd3
   } state_e;

   // Counter width large enough to reach the largest of the three limits.
   function automatic int cnt_width(int hold, int stagger, int timeout);
      int m;
      m = hold;
      if (stagger > m) m = stagger;
      if (timeout > m) m = timeout;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_seq_watchdog_if.sv
// Control/status bundle between the sequencer and its consumer.
interface rst_seq_watchdog_if #(parameter int N_CH = 2);
   import rst_seq_pkg::*;

   logic                     soft_rst_i;
   logic                     kick_i;
   logic [N_CH-1:0]          rst_o;
   logic                     ready_o;
   logic                     timeout_o;
   logic [RESTART_CNT_W-1:0] restart_cnt_o;
   logic [1:0]               state_o;

   modport master (
      output soft_rst_i, kick_i,
      input  rst_o, ready_o, timeout_o, restart_cnt_o, state_o
   );

   modport slave (
      input  soft_rst_i, kick_i,
      output rst_o, ready_o, timeout_o, restart_cnt_o, state_o
   );
endinterface

// File: rtl/rst_seq_watchdog_wdt_counter.sv
// Up-counter with sync clear/enable and terminal-count flag at limit-1.
module wdt_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             tc_o
);
   logic [CNT_W-1:0] cnt;

   // Count register; clear beats enable.
   always_ff @(posedge clk_i) begin
      if (!reset_i)   cnt <= '0;
      else if (clr_i) cnt <= '0;
      else if (en_i)  cnt <= cnt + CNT_W'(1);
   end

   assign tc_o = (cnt == (limit_i - CNT_W'(1)));
endmodule

// File: rtl/rst_seq_watchdog.sv
// Staggered reset sequencer with kickable run watchdog and restart counter.
module rst_seq_watchdog
   import rst_seq_pkg::*;
#(
   parameter int N_CH           = 2,
   parameter int HOLD_CYCLES    = 4,
   parameter int STAGGER_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 2500,
   parameter int AUTO_RESTART   = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   rst_seq_watchdog_if.slave bus
);
   localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam bit ONE_SHOT = (N_CH == 1) || (STAGGER_CYCLES == 0);
   localparam bit WD_OFF   = (TIMEOUT_CYCLES == 0);

   state_e                   state;
   logic [CH_W-1:0]          ch_idx;
   logic [N_CH-1:0]          rst_r;
   logic                     ready_r;
   logic                     timeout_r;
   logic [RESTART_CNT_W-1:0] restart_cnt;

   logic             seq_tc, wd_tc;
   logic             seq_clr, wd_clr, wd_en;
   logic [CNT_W-1:0] seq_limit;
   logic             expire;

   // Sequence counter limit follows the phase it is timing.
   assign seq_limit = (state == HOLD) ? CNT_W'(HOLD_CYCLES) : CNT_W'(STAGGER_CYCLES);
   assign seq_clr   = bus.soft_rst_i | seq_tc | !((state == HOLD) || (state == RELEASE));

   // Watchdog only runs in RUN; any kick, restart or non-RUN state zeroes it.
   assign wd_en  = (state == RUN);
   assign wd_clr = bus.soft_rst_i | bus.kick_i | (state != RUN) | WD_OFF;
   assign expire = (state == RUN) & wd_tc & ~bus.kick_i & ~WD_OFF;

   wdt_counter #(.CNT_W(CNT_W)) u_seq_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (seq_clr),
      .en_i    (1'b1),
      .limit_i (seq_limit),
      .tc_o    (seq_tc)
   );

   wdt_counter #(.CNT_W(CNT_W)) u_wd_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (wd_clr),
      .en_i    (wd_en),
      .limit_i (CNT_W'(TIMEOUT_CYCLES)),
      .tc_o    (wd_tc)
   );

   // Main FSM: reset > soft restart > per-state sequencing / expiry.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state       <= HOLD;
         ch_idx      <= '0;
         rst_r       <= '1;
         ready_r     <= 1'b0;
         timeout_r   <= 1'b0;
         restart_cnt <= '0;
      end else if (bus.soft_rst_i) begin
         state   <= HOLD;
         ch_idx  <= '0;
         rst_r   <= '1;
         ready_r <= 1'b0;
      end else begin
         case (state)
            HOLD: if (seq_tc) begin
               ch_idx <= CH_W'(1);
               if (ONE_SHOT) begin
                  rst_r   <= '0;
                  ready_r <= 1'b1;
                  state   <= RUN;
               end else begin
                  rst_r[0] <= 1'b0;
                  state    <= RELEASE;
               end
            end
            RELEASE: if (seq_tc) begin
               for (int k = 0; k < N_CH; k++)
                  if (CH_W'(k) == ch_idx) rst_r[k] <= 1'b0;
               ch_idx <= ch_idx + CH_W'(1);
               if (ch_idx == CH_W'(N_CH - 1)) begin
                  ready_r <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: if (expire) begin
               state     <= EXPIRED;
               rst_r     <= '1;
               ready_r   <= 1'b0;
               timeout_r <= 1'b1;
               if (restart_cnt != '1) restart_cnt <= restart_cnt + 1'b1;
            end
            EXPIRED: if (AUTO_RESTART != 0) begin
               state  <= HOLD;
               ch_idx <= '0;
            end
            default: state <= HOLD;
         endcase
      end
   end

   assign bus.rst_o         = rst_r;
   assign bus.ready_o       = ready_r;
   assign bus.timeout_o     = timeout_r;
   assign bus.restart_cnt_o = restart_cnt;
   assign bus.state_o       = state;
endmodule

// File: tb/tb_rst_seq_watchdog.sv
// Directed bench: four configurations of the sequencer exercised in turn.
module tb_rst_seq_watchdog;
   logic clk = 1'b0;
   logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rst_seq_watchdog_if #(.N_CH(2)) ifa ();
   rst_seq_watchdog_if #(.N_CH(2)) ifb ();
   rst_seq_watchdog_if #(.N_CH(4)) ifc ();
   rst_seq_watchdog_if #(.N_CH(2)) ifd ();

   // A: defaults with short timeout, auto restart
   rst_seq_watchdog #(.N_CH(2), .HOLD_CYCLES(4), .STAGGER_CYCLES(2),
                      .TIMEOUT_CYCLES(10), .AUTO_RESTART(1))
      dut_a (.clk_i(clk), .reset_i(rst_a), .bus(ifa));
   // B: manual restart
   rst_seq_watchdog #(.N_CH(2), .HOLD_CYCLES(4), .STAGGER_CYCLES(2),
                      .TIMEOUT_CYCLES(10), .AUTO_RESTART(0))
      dut_b (.clk_i(clk), .reset_i(rst_b), .bus(ifb));
   // C: four channels released together
   rst_seq_watchdog #(.N_CH(4), .HOLD_CYCLES(4), .STAGGER_CYCLES(0),
                      .TIMEOUT_CYCLES(2500), .AUTO_RESTART(1))
      dut_c (.clk_i(clk), .reset_i(rst_c), .bus(ifc));
   // D: watchdog disabled
   rst_seq_watchdog #(.N_CH(2), .HOLD_CYCLES(4), .STAGGER_CYCLES(2),
                      .TIMEOUT_CYCLES(0), .AUTO_RESTART(1))
      dut_d (.clk_i(clk), .reset_i(rst_d), .bus(ifd));

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      ifa.soft_rst_i = 0; ifa.kick_i = 0;
      ifb.soft_rst_i = 0; ifb.kick_i = 0;
      ifc.soft_rst_i = 0; ifc.kick_i = 0;
      ifd.soft_rst_i = 0; ifd.kick_i = 0;

      // 1: reset and staggered release
      step(3);
      check("a_rst_reset",   32'(ifa.rst_o), 32'h3);
      check("a_ready_reset", 32'(ifa.ready_o), 0);
      check("a_to_reset",    32'(ifa.timeout_o), 0);
      check("a_cnt_reset",   32'(ifa.restart_cnt_o), 0);
      check("a_st_reset",    32'(ifa.state_o), 0);
      rst_a = 1;
      step(3);
      check("a_rst_e3", 32'(ifa.rst_o), 32'h3);
      step(1);
      check("a_rst_e4", 32'(ifa.rst_o), 32'h2);
      check("a_st_e4",  32'(ifa.state_o), 1);
      step(1);
      check("a_rst_e5",   32'(ifa.rst_o), 32'h2);
      check("a_ready_e5", 32'(ifa.ready_o), 0);
      step(1);
      check("a_rst_e6",   32'(ifa.rst_o), 32'h0);
      check("a_ready_e6", 32'(ifa.ready_o), 1);
      check("a_st_e6",    32'(ifa.state_o), 2);

      // 2: kicked every 9 cycles for 100 cycles
      for (int i = 1; i <= 100; i++) begin
         ifa.kick_i = (i % 9 == 0);
         step(1);
      end
      ifa.kick_i = 0;
      check("a_to_kicked",  32'(ifa.timeout_o), 0);
      check("a_rst_kicked", 32'(ifa.rst_o), 0);
      check("a_cnt_kicked", 32'(ifa.restart_cnt_o), 0);
      check("a_st_kicked",  32'(ifa.state_o), 2);
      ifa.kick_i = 1; step(1); ifa.kick_i = 0;   // wd = 0

      // 5a: kick on the would-be expiry edge
      step(9);
      ifa.kick_i = 1; step(1); ifa.kick_i = 0;
      check("a_st_kick_tc",  32'(ifa.state_o), 2);
      check("a_to_kick_tc",  32'(ifa.timeout_o), 0);
      // 5b: soft restart on the would-be expiry edge
      step(9);
      ifa.soft_rst_i = 1; step(1); ifa.soft_rst_i = 0;
      check("a_st_soft_tc",  32'(ifa.state_o), 0);
      check("a_to_soft_tc",  32'(ifa.timeout_o), 0);
      check("a_cnt_soft_tc", 32'(ifa.restart_cnt_o), 0);
      check("a_rst_soft_tc", 32'(ifa.rst_o), 32'h3);
      // 5c: reset during RELEASE
      step(5);
      check("a_rst_rel", 32'(ifa.rst_o), 32'h2);
      check("a_st_rel",  32'(ifa.state_o), 1);
      rst_a = 0; step(1);
      check("a_rst_abort", 32'(ifa.rst_o), 32'h3);
      check("a_st_abort",  32'(ifa.state_o), 0);
      rst_a = 1;
      step(3);
      check("a_rst_re3", 32'(ifa.rst_o), 32'h3);
      step(3);
      check("a_rst_re6",   32'(ifa.rst_o), 32'h0);
      check("a_ready_re6", 32'(ifa.ready_o), 1);

      // 3: no kick -> expiry on 10th RUN edge, auto restart
      step(9);
      check("a_st_pre_exp", 32'(ifa.state_o), 2);
      step(1);
      check("a_st_exp",    32'(ifa.state_o), 3);
      check("a_rst_exp",   32'(ifa.rst_o), 32'h3);
      check("a_to_exp",    32'(ifa.timeout_o), 1);
      check("a_cnt_exp",   32'(ifa.restart_cnt_o), 1);
      check("a_ready_exp", 32'(ifa.ready_o), 0);
      step(1);
      check("a_st_rehold", 32'(ifa.state_o), 0);
      step(3);
      check("a_rst_h3", 32'(ifa.rst_o), 32'h3);
      step(1);
      check("a_rst_h4", 32'(ifa.rst_o), 32'h2);
      step(2);
      check("a_rst_h6",   32'(ifa.rst_o), 32'h0);
      check("a_ready_h6", 32'(ifa.ready_o), 1);
      check("a_to_h6",    32'(ifa.timeout_o), 1);

      // 6c: repeated expiries, 17 edges per cycle, saturating count
      step(17 * 253);
      check("a_cnt_254", 32'(ifa.restart_cnt_o), 254);
      check("a_st_254",  32'(ifa.state_o), 2);
      step(17 * 50);
      check("a_cnt_sat", 32'(ifa.restart_cnt_o), 255);

      // 4: manual restart
      rst_b = 1;
      step(6);
      check("b_ready_run", 32'(ifb.ready_o), 1);
      ifb.kick_i = 1; step(1); ifb.kick_i = 0;   // kick in RUN, wd = 0
      step(10);
      check("b_st_exp",  32'(ifb.state_o), 3);
      check("b_cnt_exp", 32'(ifb.restart_cnt_o), 1);
      ifb.kick_i = 1;
      step(50);
      ifb.kick_i = 0;
      check("b_st_held",  32'(ifb.state_o), 3);
      check("b_rst_held", 32'(ifb.rst_o), 32'h3);
      check("b_rdy_held", 32'(ifb.ready_o), 0);
      ifb.soft_rst_i = 1; step(1); ifb.soft_rst_i = 0;
      check("b_st_soft",  32'(ifb.state_o), 0);
      check("b_to_soft",  32'(ifb.timeout_o), 1);
      step(4);
      check("b_rst_e4", 32'(ifb.rst_o), 32'h2);
      step(2);
      check("b_rst_e6",  32'(ifb.rst_o), 32'h0);
      check("b_st_e6",   32'(ifb.state_o), 2);
      check("b_cnt_e6",  32'(ifb.restart_cnt_o), 1);

      // 6a: all four channels fall together
      rst_c = 1;
      step(3);
      check("c_rst_e3", 32'(ifc.rst_o), 32'hf);
      check("c_st_e3",  32'(ifc.state_o), 0);
      step(1);
      check("c_rst_e4",   32'(ifc.rst_o), 32'h0);
      check("c_ready_e4", 32'(ifc.ready_o), 1);
      check("c_st_e4",    32'(ifc.state_o), 2);

      // 6b: watchdog disabled
      rst_d = 1;
      step(6);
      check("d_ready_e6", 32'(ifd.ready_o), 1);
      step(10000);
      check("d_st_long",  32'(ifd.state_o), 2);
      check("d_to_long",  32'(ifd.timeout_o), 0);
      check("d_rst_long", 32'(ifd.rst_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rst_seq_watchdog.md
Name: rst_seq_watchdog

Overview:
- Synthesizable reset sequencer and run watchdog, placed between the board/top-level reset and the cpu core plus its peripherals.
- Generalises the fixed bench reset pulse and fixed run timeout into parameters, with these additions:
  - N staggered reset channels
  - a kickable watchdog
  - automatic or manual restart on expiry
  - a restart counter for debug.

Parameters:
N_CH, 2, number of reset output channels (1..16)
HOLD_CYCLES, 4, cycles all rst_o stay high after reset_i release or restart (>=1)
STAGGER_CYCLES, 2, cycles between release of channel k-1 and channel k (0 = all release together)
TIMEOUT_CYCLES, 2500, RUN cycles without kick before expiry (0 = watchdog disabled)
AUTO_RESTART, 1, 1: expiry re-enters HOLD automatically; 0: stay EXPIRED until soft_rst_i
CNT_W, derived, $clog2(max(HOLD_CYCLES,STAGGER_CYCLES,TIMEOUT_CYCLES)+1)

Ports:
clk_i  in  1  single clock, rising edge
reset_i  in  1  synchronous, active-low reset
soft_rst_i  in  1  software restart request, level sampled each edge
kick_i  in  1  watchdog kick, clears the run counter
rst_o  out  N_CH  active-high per-channel resets (drive the cpu reset_i)
ready_o  out  1  all channels released, state RUN
timeout_o  out  1  sticky, a watchdog expiry has occurred
restart_cnt_o  out  8  count of expiries, saturating at 255
state_o  out  2  current state encoding, for debug

Behaviour:
Reset:
- reset_i low is sampled at an edge only (synchronous).
- On that edge: state=HOLD, cnt=0, ch_idx=0, rst_o=all 1, ready_o=0, timeout_o=0, restart_cnt_o=0.

States: HOLD=0, RELEASE=1, RUN=2, EXPIRED=3.

HOLD:
- cnt increments each edge.
- At cnt==HOLD_CYCLES-1: rst_o[0]<=0, cnt<=0, ch_idx<=1.
- If N_CH==1 or STAGGER_CYCLES==0: all rst_o<=0 and go to RUN; otherwise go to RELEASE.
- Effect: rst_o stays all 1 for exactly HOLD_CYCLES edges after the first edge with reset_i=1.

RELEASE:
- cnt increments each edge.
- At cnt==STAGGER_CYCLES-1: rst_o[ch_idx]<=0, ch_idx++, cnt<=0.
- When the last channel is released, go to RUN.
- Channels release strictly in index order and never re-assert except via HOLD.

RUN:
- ready_o=1, registered in the same edge that clears the last rst_o bit.
- Watchdog counter wd increments each edge; kick_i=1 sets wd<=0.
- At wd==TIMEOUT_CYCLES-1 with kick_i=0: go to EXPIRED, all rst_o<=1, ready_o<=0, timeout_o<=1, restart_cnt_o++ (saturating).
- TIMEOUT_CYCLES==0: wd is held at 0 and expiry never occurs.

EXPIRED:
- rst_o stays all 1.
- AUTO_RESTART=1: next edge goes to HOLD with cnt=0.
- AUTO_RESTART=0: holds until soft_rst_i.

soft_rst_i:
- Valid in any state, sampled at an edge.
- Next state is HOLD with cnt=wd=ch_idx=0, all rst_o<=1, ready_o<=0.
- timeout_o and restart_cnt_o are preserved.

Priority per edge: reset_i low > soft_rst_i > kick_i > expiry.
- kick_i on the expiry cycle prevents the timeout.
- soft_rst_i on the expiry cycle means HOLD with no timeout_o set and no count increment.

Other rules:
- Mid-sequence reset_i low aborts immediately to reset values.
- kick_i outside RUN is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package rst_seq_pkg holds:
  - state_e enum (2-bit, encodings above)
  - function cnt_width(hold, stagger, timeout)
  - localparam RESTART_CNT_W=8.
- One sub-module, wdt_counter: CNT_W up-counter with sync clear, enable and terminal-count compare (tc_o when count==limit_i-1).
- wdt_counter is instantiated twice: sequence cnt and watchdog wd.
- The FSM and channel release logic stay in rst_seq_watchdog.

Test Plan:
1. Defaults, TIMEOUT_CYCLES=10, reset_i=0 for 3 edges then 1 -> rst_o=2'b11 for 4 edges; rst_o=2'b10 at edge 4; rst_o=2'b00 and ready_o=1 at edge 6; state_o=2.
2. RUN with kick_i pulsed every 9 cycles for 100 cycles -> timeout_o stays 0, rst_o stays 00, restart_cnt_o=0.
3. No kick after RUN entry -> EXPIRED on the 10th edge; rst_o=11, timeout_o=1, restart_cnt_o=1; HOLD next edge; release repeats as in scenario 1; timeout_o stays 1.
4. AUTO_RESTART=0, expiry -> state_o=3, rst_o=11 held for 50 cycles; soft_rst_i pulse -> HOLD, then normal release; restart_cnt_o=1.
5. Same-edge events:
   - kick_i on wd==9 -> no expiry
   - soft_rst_i on wd==9 -> HOLD, timeout_o=0
   - reset_i=0 during RELEASE with rst_o=10 -> next edge rst_o=11, all counters 0.
6. Corner configs: N_CH=4/STAGGER_CYCLES=0 -> all bits fall on one edge after 4 HOLD edges; TIMEOUT_CYCLES=0 -> no expiry over 10000 cycles; 300 forced expiries -> restart_cnt_o=255.
